// File: rtl/keypad_key_capture_pkg.sv
// Shared keypad definitions: key count, slot-index width, key FSM states and
// small bitmap helpers used by the capture logic.
package keypad_pkg;
  localparam int NUM_KEYS  = 12;
  localparam int KEY_IDX_W = 4;

  typedef logic [NUM_KEYS-1:0]  frame_t;
  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  typedef enum logic [1:0] {IDLE, PRESSED, MULTI} key_state_t;

  function automatic key_idx_t count_keys(frame_t f);
    key_idx_t c = '0;
    for (int i = 0; i < NUM_KEYS; i++) c = c + key_idx_t'(f[i]);
    return c;
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic key_idx_t lowest_key(frame_t f);
    key_idx_t k = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) if (f[i]) k = key_idx_t'(i);
    return k;
  endfunction
endpackage

// File: rtl/keypad_key_capture_if.sv
// Scan-sample input bus and key-event outputs of the keypad capture block.
interface keypad_key_capture_if;
  import keypad_pkg::*;

  key_idx_t SCAN_IDX;
  logic     SCAN_BIT;
  logic     SAMPLE_EN;
  key_idx_t KEY_CODE;
  logic     KEY_VALID;
  logic     KEY_HELD;
  logic     MULTI_ERR;

  modport master (output SCAN_IDX, SCAN_BIT, SAMPLE_EN,
                  input  KEY_CODE, KEY_VALID, KEY_HELD, MULTI_ERR);
  modport slave  (input  SCAN_IDX, SCAN_BIT, SAMPLE_EN,
                  output KEY_CODE, KEY_VALID, KEY_HELD, MULTI_ERR);
endinterface

// File: rtl/keypad_frame_debounce.sv
// Frame debouncer: a completed frame becomes stable after DEBOUNCE_FRAMES
// consecutive identical completed frames.
module keypad_frame_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   frame_done,
  input  frame_t frame,
  output logic   stable_upd,
  output frame_t stable_frame
);
  localparam logic [2:0] DB = 3'(DEBOUNCE_FRAMES);

  frame_t     prev_q, stable_q;
  logic [2:0] cnt_q, cnt_nxt;

  always_comb begin
    cnt_nxt = 3'd1;
    if (frame == prev_q) cnt_nxt = (cnt_q == DB) ? cnt_q : cnt_q + 3'd1;
  end

  // Saturated counter keeps re-announcing the same stable frame each frame.
  assign stable_upd   = frame_done && (cnt_nxt == DB);
  assign stable_frame = stable_upd ? frame : stable_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else if (frame_done) begin
      prev_q <= frame;
      cnt_q  <= cnt_nxt;
      if (stable_upd) stable_q <= frame;
    end
  end
endmodule

// File: rtl/keypad_key_capture.sv
// Keypad key capture: frame assembly, debounce and key FSM.
// Optional auto-repeat of KEY_VALID while a key is held: define KEY_AUTOREPEAT_EN.
module keypad_key_capture
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 50
) (
  input logic CLK,
  input logic RST,
  keypad_key_capture_if.slave bus
);
  localparam key_idx_t LAST_IDX = key_idx_t'(NUM_KEYS - 1);

  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 7 ||
      REPEAT_FRAMES < 2 || REPEAT_FRAMES > 255) begin : g_bad_cfg
    $error("keypad_key_capture: parameter out of range");
  end

  // exp_q == 0 means no frame in progress; waiting for an index-0 sample.
  key_idx_t exp_q;
  frame_t   bitmap_q, frame_w;
  logic     in_seq, frame_done;

  assign in_seq     = bus.SAMPLE_EN && (exp_q != '0) && (bus.SCAN_IDX == exp_q);
  assign frame_done = in_seq && (bus.SCAN_IDX == LAST_IDX);

  always_comb begin
    frame_w = bitmap_q;
    for (int i = 0; i < NUM_KEYS; i++)
      if (key_idx_t'(i) == bus.SCAN_IDX) frame_w[i] = bus.SCAN_BIT;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      exp_q    <= '0;
      bitmap_q <= '0;
    end else if (bus.SAMPLE_EN) begin
      if (bus.SCAN_IDX == '0) begin
        bitmap_q <= frame_t'(bus.SCAN_BIT);
        exp_q    <= key_idx_t'(1);
      end else if (in_seq) begin
        bitmap_q <= frame_w;
        exp_q    <= frame_done ? '0 : exp_q + key_idx_t'(1);
      end else begin
        bitmap_q <= '0;
        exp_q    <= '0;
      end
    end
  end

  logic   stable_upd;
  frame_t stable_frame;

  keypad_frame_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
    .CLK          (CLK),
    .RST          (RST),
    .frame_done   (frame_done),
    .frame        (frame_w),
    .stable_upd   (stable_upd),
    .stable_frame (stable_frame)
  );

  key_state_t state_q, state_nxt;
  key_idx_t   key_code_q, n_keys, new_key;
  logic       key_valid_q, key_held_q, multi_err_q;
  logic       accept, rpt_fire;

  assign n_keys  = count_keys(stable_frame);
  assign new_key = lowest_key(stable_frame);

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    if (stable_upd) begin
      if (n_keys == '0) begin
        state_nxt = IDLE;
      end else if (n_keys == key_idx_t'(1)) begin
        state_nxt = PRESSED;
        accept    = (state_q != PRESSED) || (new_key != key_code_q);
      end else begin
        state_nxt = MULTI;
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  logic [7:0] rpt_q;
  logic       change;

  // Roll-over to a new key counts as a state change and restarts the period.
  assign change   = (state_nxt != state_q) || accept;
  assign rpt_fire = (state_q == PRESSED) && frame_done && !change &&
                    (rpt_q == 8'(REPEAT_FRAMES - 1));

  always_ff @(posedge CLK) begin
    if (!RST)                                   rpt_q <= '0;
    else if (change)                            rpt_q <= '0;
    else if (state_q == PRESSED && frame_done)  rpt_q <= rpt_fire ? 8'd0 : rpt_q + 8'd1;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      key_valid_q <= accept || rpt_fire;
      if (accept) key_code_q <= new_key;
      key_held_q  <= (state_nxt == PRESSED);
      multi_err_q <= (state_nxt == MULTI);
    end
  end

  assign bus.KEY_CODE  = key_code_q;
  assign bus.KEY_VALID = key_valid_q;
  assign bus.KEY_HELD  = key_held_q;
  assign bus.MULTI_ERR = multi_err_q;
endmodule

// File: tb/tb_keypad_key_capture.sv
// Bench for keypad_key_capture: frame-level vector table, hand-written corner
// sequences and randomized frames, all checked cycle by cycle against a model.
module tb_keypad_key_capture;
  import keypad_pkg::*;

  localparam int DB  = 4;
  localparam int RPT = 3;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  keypad_key_capture_if bus();

  keypad_key_capture #(.DEBOUNCE_FRAMES(DB), .REPEAT_FRAMES(RPT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  // Reference model state: frame under assembly, recent completed frames, key view.
  int     cur[$];
  frame_t hist[$];
  logic   m_valid = 1'b0, m_held = 1'b0, m_merr = 1'b0;
  int     m_code = 0;
  int     m_rpt = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst_v, input logic en, input logic [3:0] idx, input logic b);
    frame_t f = '0;
    bit     done = 0, upd = 0, held0;
    int     n, k = 0, code0;
    m_valid = 1'b0;
    if (!rst_v) begin
      cur.delete(); hist.delete();
      m_held = 0; m_merr = 0; m_code = 0; m_rpt = 0;
      return;
    end
    if (en) begin
      if (idx == 0) begin
        cur.delete(); cur.push_back(int'(b));
      end else if (cur.size() > 0 && cur.size() == int'(idx)) cur.push_back(int'(b));
      else cur.delete();
      if (cur.size() == NUM_KEYS) begin
        for (int i = 0; i < NUM_KEYS; i++) f[i] = cur[i][0];
        done = 1;
        cur.delete();
        hist.push_back(f);
        if (hist.size() > DB) void'(hist.pop_front());
      end
    end
    if (done && hist.size() == DB) begin
      upd = 1;
      foreach (hist[j]) if (hist[j] != f) upd = 0;
    end
    held0 = m_held; code0 = m_code;
    if (upd) begin
      n = $countones(f);
      if (n == 0) begin
        m_held = 0; m_merr = 0;
      end else if (n == 1) begin
        for (int j = 0; j < NUM_KEYS; j++) if (f[j]) k = j;
        if (!m_held || m_code != k) begin
          m_valid = 1; m_code = k; m_rpt = 0;
        end
        m_held = 1; m_merr = 0;
      end else begin
        m_held = 0; m_merr = 1;
      end
    end
`ifdef KEY_AUTOREPEAT_EN
    if (done && held0 && m_held && m_code == code0 && !m_valid) begin
      m_rpt++;
      if (m_rpt == RPT) begin
        m_valid = 1; m_rpt = 0;
      end
    end
`endif
  endtask

  task automatic drive(input logic rst_v, input logic en, input logic [3:0] idx, input logic b);
    @(negedge CLK);
    RST = rst_v; bus.SAMPLE_EN = en; bus.SCAN_IDX = idx; bus.SCAN_BIT = b;
    @(posedge CLK);
    model_step(rst_v, en, idx, b);
    #1;
    check("key_valid", int'(bus.KEY_VALID), int'(m_valid));
    check("key_code",  int'(bus.KEY_CODE),  m_code);
    check("key_held",  int'(bus.KEY_HELD),  int'(m_held));
    check("multi_err", int'(bus.MULTI_ERR), int'(m_merr));
    if (bus.KEY_VALID === 1'b1) pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b1);
  endtask

  task automatic send_frame(input frame_t f, input int gap);
    for (int i = 0; i < NUM_KEYS; i++) begin
      drive(1'b1, 1'b1, 4'(i), f[i]);
      idle($urandom_range(0, gap));
    end
  endtask

  typedef struct {
    frame_t f;
    int     nfr;
    int     exp_pulses;
    int     exp_code;
    int     exp_held;
    int     exp_merr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    frame_t f;
    bus.SAMPLE_EN = 1'b0; bus.SCAN_IDX = '0; bus.SCAN_BIT = 1'b0;

    tbl[0] = '{12'h020, 4, 1,  5, 1, 0};
    tbl[1] = '{12'h000, 4, 0,  5, 0, 0};
    tbl[2] = '{12'h020, 3, 0,  5, 0, 0};
    tbl[3] = '{12'h000, 4, 0,  5, 0, 0};
    tbl[4] = '{12'h084, 4, 0,  5, 0, 1};
    tbl[5] = '{12'h080, 4, 1,  7, 1, 0};
    tbl[6] = '{12'h800, 4, 1, 11, 1, 0};
    tbl[7] = '{12'h001, 4, 1,  0, 1, 0};
    tbl[8] = '{12'h000, 4, 0,  0, 0, 0};

    do_reset(2);
    check("reset_code",  int'(bus.KEY_CODE), 0);
    check("reset_valid", int'(bus.KEY_VALID), 0);
    check("reset_held",  int'(bus.KEY_HELD), 0);
    check("reset_merr",  int'(bus.MULTI_ERR), 0);

    foreach (tbl[v]) begin
      pulses = 0;
      for (int n = 0; n < tbl[v].nfr; n++) send_frame(tbl[v].f, 1);
`ifndef KEY_AUTOREPEAT_EN
      check($sformatf("tbl%0d_pulses", v), pulses, tbl[v].exp_pulses);
`endif
      check($sformatf("tbl%0d_code", v), int'(bus.KEY_CODE),  tbl[v].exp_code);
      check($sformatf("tbl%0d_held", v), int'(bus.KEY_HELD),  tbl[v].exp_held);
      check($sformatf("tbl%0d_merr", v), int'(bus.MULTI_ERR), tbl[v].exp_merr);
    end

    // Out-of-order index discards the partial frame, including its tail.
    do_reset(1);
    for (int i = 0; i <= 5; i++) drive(1'b1, 1'b1, 4'(i), i == 5);
    drive(1'b1, 1'b1, 4'd8, 1'b0);
    for (int i = 9; i <= 11; i++) drive(1'b1, 1'b1, 4'(i), 1'b0);
    pulses = 0;
    for (int n = 0; n < 3; n++) send_frame(12'h020, 0);
    check("discard_3frames_pulses", pulses, 0);
    send_frame(12'h020, 0);
    check("discard_4th_pulses", pulses, 1);
    check("discard_code", int'(bus.KEY_CODE), 5);

    // Reset during the third frame of a slot-3 press.
    send_frame(12'h008, 0);
    send_frame(12'h008, 0);
    for (int i = 0; i <= 5; i++) drive(1'b1, 1'b1, 4'(i), i == 3);
    do_reset(3);
    check("midrst_code",  int'(bus.KEY_CODE), 0);
    check("midrst_held",  int'(bus.KEY_HELD), 0);
    check("midrst_merr",  int'(bus.MULTI_ERR), 0);
    check("midrst_valid", int'(bus.KEY_VALID), 0);
    for (int i = 6; i <= 11; i++) drive(1'b1, 1'b1, 4'(i), i == 3);
    pulses = 0;
    for (int n = 0; n < 3; n++) send_frame(12'h008, 1);
    check("midrst_3frames_pulses", pulses, 0);
    send_frame(12'h008, 1);
    check("midrst_4th_pulses", pulses, 1);
    check("midrst_key3", int'(bus.KEY_CODE), 3);

    // Long hold of slot 9: one press pulse, plus repeats when enabled.
    do_reset(1);
    pulses = 0;
    for (int n = 0; n < 13; n++) send_frame(12'h200, 1);
`ifdef KEY_AUTOREPEAT_EN
    check("hold_pulses", pulses, 4);
`else
    check("hold_pulses", pulses, 1);
`endif
    check("hold_code", int'(bus.KEY_CODE), 9);
    check("hold_held", int'(bus.KEY_HELD), 1);

    // Randomized frames with glitches and occasional resets.
    do_reset(1);
    for (int it = 0; it < 150; it++) begin
      f = '0;
      case ($urandom_range(0, 3))
        0: f = '0;
        1, 2: f[$urandom_range(0, NUM_KEYS - 1)] = 1'b1;
        default: begin
          f[$urandom_range(0, NUM_KEYS - 1)] = 1'b1;
          f[$urandom_range(0, NUM_KEYS - 1)] = 1'b1;
        end
      endcase
      for (int n = $urandom_range(1, 6); n > 0; n--) begin
        send_frame(f, 1);
        if ($urandom_range(0, 9) == 0) drive(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b1);
      end
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/keypad_key_capture.md
KEYPAD_KEY_CAPTURE -- requirements
Module: keypad_key_capture

Interface
REQ-001 Parameter DEBOUNCE_FRAMES, default 4 (range 1..7): number of consecutive identical scan frames needed to accept a state change.
REQ-002 Parameter REPEAT_FRAMES, default 50 (range 2..255): frames between auto-repeat pulses (used only with KEY_AUTOREPEAT_EN).
REQ-003 CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-low.
REQ-005 SCAN_IDX  input  4  key slot currently presented by the digit selecter, 0..11.
REQ-006 SCAN_BIT  input  1  selecter serial output for SCAN_IDX; 1 = key pressed.
REQ-007 SAMPLE_EN  input  1  one-cycle strobe; SCAN_IDX/SCAN_BIT are valid and are sampled this cycle.
REQ-008 KEY_CODE  output  4  slot index of the accepted key; held until the next accepted key.
REQ-009 KEY_VALID  output  1  one-cycle pulse, coincident with a KEY_CODE update.
REQ-010 KEY_HELD  output  1  high while the accepted key is debounced-pressed.
REQ-011 MULTI_ERR  output  1  high while the debounced frame has two or more pressed slots.

Function
REQ-012 Frame assembly: on SAMPLE_EN, SCAN_BIT is written into bitmap bit SCAN_IDX; expected index advances 0->1->..->11.
REQ-013 A sample with SCAN_IDX equal to the expected index is accepted; a sample with SCAN_IDX = 0 always restarts the frame (bitmap cleared, expected = 1).
REQ-014 Any other out-of-order index, or SCAN_IDX > 11, discards the partial frame; assembly resumes at the next index-0 sample.
REQ-015 Accepting index 11 completes a frame: the 12-bit bitmap is presented to the debouncer with a one-cycle frame_done.
REQ-016 Debouncer: a completed frame equal to the previous completed frame increments a match counter (saturating at DEBOUNCE_FRAMES); a different frame resets it to 1.
REQ-017 The frame becomes the stable frame when the counter reaches DEBOUNCE_FRAMES.
REQ-018 FSM states IDLE, PRESSED, MULTI; evaluated only when the stable frame updates.
REQ-019 IDLE -> PRESSED when the stable frame has exactly one bit set: KEY_CODE = that index, KEY_VALID pulses one cycle after the completing sample, KEY_HELD = 1.
REQ-020 Any state -> MULTI when the stable frame has >=2 bits set: MULTI_ERR = 1, KEY_HELD = 0, no KEY_VALID.
REQ-021 PRESSED or MULTI -> IDLE when the stable frame is all-zero; KEY_HELD = 0, MULTI_ERR = 0, KEY_CODE retained.
REQ-022 PRESSED with a different single key stable (direct roll-over) -> PRESSED with new KEY_CODE and a new KEY_VALID pulse.
REQ-023 MULTI -> PRESSED on a stable single key, with a KEY_VALID pulse for that key.
REQ-024 Total latency: KEY_VALID rises exactly 1 cycle after the SAMPLE_EN of index 11 in the DEBOUNCE_FRAMES-th identical frame.

Reset
REQ-025 While RST = 0 at a clock edge: FSM = IDLE, bitmap, previous frame, stable frame = 0, match counter = 0, expected index = 0, repeat counter = 0.
REQ-026 Reset values: KEY_CODE = 0, KEY_VALID = 0, KEY_HELD = 0, MULTI_ERR = 0; samples during reset are ignored.
REQ-027 Reset mid-frame or mid-debounce discards all progress; the first accepted frame after release needs a full DEBOUNCE_FRAMES.

Configuration
REQ-028 Macro KEY_AUTOREPEAT_EN defined: in PRESSED, a frame counter counts completed frames; every REPEAT_FRAMES frames KEY_VALID pulses again with unchanged KEY_CODE; the counter clears on any state change.
REQ-029 KEY_AUTOREPEAT_EN undefined: exactly one KEY_VALID per accepted press; no repeat counter logic is generated.

Structure
REQ-030 Shared package keypad_pkg holds NUM_KEYS = 12, KEY_IDX_W = 4, and the state enumeration (IDLE, PRESSED, MULTI).
REQ-031 Sub-module keypad_frame_debounce (bitmap compare, match counter, stable frame output); the frame assembler and FSM are in the top.

Verification
REQ-032 Frames with only slot 5 pressed, 4 in a row -> KEY_VALID single pulse 1 cycle after the 4th index-11 sample, KEY_CODE = 5, KEY_HELD = 1.
REQ-033 Slot 5 pressed for 3 frames then all-zero -> no KEY_VALID, KEY_HELD stays 0.
REQ-034 Slots 2 and 7 pressed for 4 frames -> MULTI_ERR = 1, no KEY_VALID; then slot 7 alone for 4 frames -> KEY_VALID, KEY_CODE = 7, MULTI_ERR = 0.
REQ-035 Sequence 0..5, then 8 -> frame discarded; the next full 0..11 frame is counted as frame 1.
REQ-036 RST = 0 asserted during the 3rd frame of a slot-3 press -> all outputs 0; 4 further clean frames are required before KEY_VALID.
REQ-037 With KEY_AUTOREPEAT_EN and REPEAT_FRAMES = 3, slot 9 held for 4 + 9 frames -> 4 KEY_VALID pulses, KEY_CODE = 9 throughout.
